// File: rtl/frame_streamer_pkg.sv
// ---------------------------------------------------------------------------
// frame_streamer_pkg
// Shared definitions for the frame streaming / edge-detection blocks:
// default image geometry and pixel width, the derived frame RAM address
// width, the streamer FSM state type and the per-pixel marker bundle.
// ---------------------------------------------------------------------------
package frame_streamer_pkg;

    localparam int PIX_BITS   = 8;
    localparam int IMG_WIDTH  = 480;
    localparam int IMG_HEIGHT = 272;

    // Bits needed to index n items; never returns less than 1 so that
    // degenerate dimensions (n = 1) still give a legal vector width.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int addr_width(input int w, input int h);
        return clog2_min1(w * h);
    endfunction

    localparam int IMG_ADDR_W = addr_width(IMG_WIDTH, IMG_HEIGHT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_HBLANK = 2'd2,
        S_DRAIN  = 2'd3
    } fs_state_t;

    typedef struct packed {
        logic sof;
        logic sol;
        logic eol;
        logic eof;
    } marks_t;

    localparam int MARK_W = $bits(marks_t);

endpackage

// File: rtl/frame_streamer_if.sv
// ---------------------------------------------------------------------------
// frame_streamer_if
// Raster pixel stream: data plus frame/line markers with a valid/ready
// handshake. A beat transfers on a rising clock edge where pix_valid and
// pix_ready are both high.
//   master : drives pix_out, pix_valid, sof, sol, eol, eof; samples pix_ready
//   slave  : samples the stream; drives pix_ready
// ---------------------------------------------------------------------------
interface frame_streamer_if #(
    parameter int BITSIZE = 8
);
    logic [BITSIZE-1:0] pix_out;
    logic               pix_valid;
    logic               pix_ready;
    logic               sof;
    logic               sol;
    logic               eol;
    logic               eof;

    modport master (
        output pix_out,
        output pix_valid,
        output sof,
        output sol,
        output eol,
        output eof,
        input  pix_ready
    );

    modport slave (
        input  pix_out,
        input  pix_valid,
        input  sof,
        input  sol,
        input  eol,
        input  eof,
        output pix_ready
    );
endinterface

// File: rtl/frame_streamer_skid2.sv
// ---------------------------------------------------------------------------
// frame_streamer_skid2
// Two-entry FIFO with a registered head. Push and pop in the same cycle are
// legal even when full (the popped slot is the one rewritten), so order is
// kept and the count stays put.
// Ports:
//   clk, rst   : clock, synchronous active-low reset (contents cleared)
//   push, din  : write request and data
//   pop        : read request; ignored when empty
//   dout       : head entry
//   count      : number of valid entries (0..2)
// ---------------------------------------------------------------------------
module frame_streamer_skid2 #(
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic [1:0]    count
);

    logic [DW-1:0] slot_q [2];
    logic [DW-1:0] slot_d [2];
    logic          rd_ptr_q, rd_ptr_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic [1:0]    count_q, count_d;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        do_pop   = pop && (count_q != 2'd0);
        do_push  = push && ((count_q != 2'd2) || do_pop);
        slot_d   = slot_q;
        rd_ptr_d = rd_ptr_q ^ do_pop;
        wr_ptr_d = wr_ptr_q ^ do_push;
        count_d  = count_q;
        if (do_push) begin
            slot_d[wr_ptr_q] = din;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            slot_q    <= slot_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
        end
    end

    assign dout  = slot_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/frame_streamer.sv
// ---------------------------------------------------------------------------
// frame_streamer
// Reads one WIDTH x HEIGHT frame from a synchronous RAM (1-cycle read
// latency) in row-major order and emits it as a pixel stream with
// sof/sol/eol/eof markers. Reads are credit-limited so the 2-entry output
// FIFO can never overflow under backpressure.
// Ports:
//   clk, rst          : clock, synchronous active-low reset
//   start             : begin a frame (only honoured when idle)
//   busy, done        : frame in progress; pulse on last-pixel handshake
//   mem_en, mem_addr  : RAM read request
//   mem_rdata         : RAM data, valid one cycle after mem_en
//   pix               : pixel stream (master side)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; counters parked at 0
// S_FETCH  | issuing one read per cycle while credit allows
// S_HBLANK | HBLANK idle cycles between lines, output keeps draining
// S_DRAIN  | all reads issued; waiting for the eof pixel to hand off
// ---------------------------------------------------------------------------
module frame_streamer
    import frame_streamer_pkg::*;
#(
    parameter int BITSIZE = PIX_BITS,
    parameter int WIDTH   = IMG_WIDTH,
    parameter int HEIGHT  = IMG_HEIGHT,
    parameter int ADDR_W  = addr_width(WIDTH, HEIGHT),
    parameter int HBLANK  = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               mem_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [BITSIZE-1:0] mem_rdata,
    frame_streamer_if.master   pix
);

    localparam int COL_W  = clog2_min1(WIDTH);
    localparam int ROW_W  = clog2_min1(HEIGHT);
    localparam int HB_W   = clog2_min1(HBLANK + 1);
    localparam int FIFO_W = BITSIZE + MARK_W;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
    // Blanking is a down-counter: load HBLANK-1, leave on terminal count 0.
    localparam logic [HB_W-1:0]  HB_LOAD  = HB_W'((HBLANK > 0) ? HBLANK - 1 : 0);

    fs_state_t          state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [HB_W-1:0]    hb_q, hb_d;
    logic               outstanding_q, outstanding_d;
    marks_t             marks_q, marks_d;

    logic [FIFO_W-1:0]  fifo_dout;
    logic [1:0]         fifo_count;
    marks_t             head_marks;
    logic [BITSIZE-1:0] head_pix;
    marks_t             fetch_marks;
    logic               pix_valid_c;
    logic               pop;
    logic               issue;
    logic               done_c;
    logic [2:0]         inflight;

    // The read issued last cycle lands in the FIFO this cycle along with
    // the markers computed when it was issued.
    frame_streamer_skid2 #(
        .DW (FIFO_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (outstanding_q),
        .din   ({marks_q, mem_rdata}),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    assign head_marks = marks_t'(fifo_dout[FIFO_W-1 -: MARK_W]);
    assign head_pix   = fifo_dout[BITSIZE-1:0];

    always_comb begin
        pix_valid_c = (fifo_count != 2'd0);
        pop         = pix_valid_c && pix.pix_ready;
        // Entries that will occupy the FIFO once the in-flight read lands;
        // a new read is only safe if that leaves room for it.
        inflight    = {1'b0, fifo_count} + {2'b00, outstanding_q} - {2'b00, pop};
        issue       = (state_q == S_FETCH) && (inflight < 3'd2);

        fetch_marks.sof = (col_q == '0) && (row_q == '0);
        fetch_marks.sol = (col_q == '0);
        fetch_marks.eol = (col_q == COL_LAST);
        fetch_marks.eof = (col_q == COL_LAST) && (row_q == ROW_LAST);

        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        addr_d        = addr_q;
        hb_d          = hb_q;
        outstanding_d = issue;
        marks_d       = issue ? fetch_marks : marks_q;
        done_c        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    col_d   = '0;
                    row_d   = '0;
                    addr_d  = '0;
                end
            end
            S_FETCH: begin
                if (issue) begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            state_d = S_DRAIN;
                        end else begin
                            row_d = row_q + ROW_W'(1);
                            if (HBLANK > 0) begin
                                state_d = S_HBLANK;
                                hb_d    = HB_LOAD;
                            end
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            S_HBLANK: begin
                if (hb_q == '0) begin
                    state_d = S_FETCH;
                end else begin
                    hb_d = hb_q - HB_W'(1);
                end
            end
            S_DRAIN: begin
                if (pop && head_marks.eof) begin
                    done_c  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            col_q         <= '0;
            row_q         <= '0;
            addr_q        <= '0;
            hb_q          <= '0;
            outstanding_q <= 1'b0;
            marks_q       <= '0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            addr_q        <= addr_d;
            hb_q          <= hb_d;
            outstanding_q <= outstanding_d;
            marks_q       <= marks_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_c;
    assign mem_en   = issue;
    assign mem_addr = addr_q;

    // Outputs are forced low when no pixel is presented so stale FIFO
    // contents never leak onto the stream.
    assign pix.pix_valid = pix_valid_c;
    assign pix.pix_out   = pix_valid_c ? head_pix : '0;
    assign pix.sof       = pix_valid_c && head_marks.sof;
    assign pix.sol       = pix_valid_c && head_marks.sol;
    assign pix.eol       = pix_valid_c && head_marks.eol;
    assign pix.eof       = pix_valid_c && head_marks.eof;

endmodule

// File: tb/tb_frame_streamer.sv
module tb_frame_streamer;

    localparam int BS   = 8;
    localparam int W    = 4;
    localparam int H    = 3;
    localparam int AW   = 4;
    localparam int NPIX = W * H;

    logic clk;
    logic rst;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    // DUT 0: back-to-back lines
    logic          start0, busy0, done0, en0;
    logic [AW-1:0] addr0;
    logic [BS-1:0] rdata0;
    frame_streamer_if #(.BITSIZE(BS)) pix0 ();

    // DUT 1: two blanking cycles between lines
    logic          start1, busy1, done1, en1;
    logic [AW-1:0] addr1;
    logic [BS-1:0] rdata1;
    frame_streamer_if #(.BITSIZE(BS)) pix1 ();

    frame_streamer #(.BITSIZE(BS), .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .HBLANK(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
        .mem_en(en0), .mem_addr(addr0), .mem_rdata(rdata0), .pix(pix0)
    );

    frame_streamer #(.BITSIZE(BS), .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .HBLANK(2)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .mem_en(en1), .mem_addr(addr1), .mem_rdata(rdata1), .pix(pix1)
    );

    // Frame RAMs: RAM[a] = a, one cycle read latency
    always_ff @(posedge clk) begin
        if (en0) rdata0 <= BS'(addr0);
        if (en1) rdata1 <= BS'(addr1);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic [7:0] pix;
        logic [3:0] mk;   // {sof, sol, eol, eof}
    } exp_t;

    exp_t frame_tbl [NPIX];
    exp_t exp_q [$];
    int   hs_cyc_q [$];
    int   en_cnt0   = 0;
    int   done_cnt0 = 0;
    int   last_done0 = -1;
    int   exp_addr0 = 0;

    int   iss_cyc1 [$];
    int   iss_addr1 [$];
    int   hs1_cyc [$];
    int   hs1_pix [$];
    int   done_cnt1 = 0;

    // Scoreboard / monitor for DUT 0, sampled mid-cycle
    initial begin
        exp_t       e;
        logic [3:0] mk;
        logic       hold_pend;
        logic [7:0] hold_pix;
        logic [3:0] hold_mk;
        hold_pend = 1'b0;
        hold_pix  = '0;
        hold_mk   = '0;
        forever begin
            @(negedge clk);
            mk = {pix0.sof, pix0.sol, pix0.eol, pix0.eof};
            if (!busy0) exp_addr0 = 0;
            if (!rst) begin
                exp_q.delete();
                hold_pend = 1'b0;
            end else begin
                if (en0) begin
                    chk("rd_addr", int'(addr0), exp_addr0);
                    exp_addr0++;
                    en_cnt0++;
                end
                if (hold_pend) begin
                    chk("hold_valid", int'(pix0.pix_valid), 1);
                    chk("hold_pix", int'(pix0.pix_out), int'(hold_pix));
                    chk("hold_marks", int'(mk), int'(hold_mk));
                end
                if (pix0.pix_valid && pix0.pix_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_pixel", int'(pix0.pix_out), -1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pix_data", int'(pix0.pix_out), int'(e.pix));
                        chk("pix_marks", int'(mk), int'(e.mk));
                    end
                    hs_cyc_q.push_back(cyc);
                end
                if (done0) begin
                    done_cnt0++;
                    last_done0 = cyc;
                    chk("done_on_eof_hs", int'(pix0.pix_valid && pix0.pix_ready && pix0.eof), 1);
                end
                hold_pend = pix0.pix_valid && !pix0.pix_ready;
                hold_pix  = pix0.pix_out;
                hold_mk   = mk;
            end
        end
    end

    // Recorder for DUT 1
    initial forever begin
        @(negedge clk);
        if (rst) begin
            if (en1) begin
                iss_cyc1.push_back(cyc);
                iss_addr1.push_back(int'(addr1));
            end
            if (pix1.pix_valid && pix1.pix_ready) begin
                hs1_cyc.push_back(cyc);
                hs1_pix.push_back(int'(pix1.pix_out));
            end
            if (done1) done_cnt1++;
        end
    end

    // mode 0: ready high, 1: random ready, 2: ready low for 20 cycles
    task automatic run_frame(input int mode);
        int c0, n, en_snap, d_snap;
        foreach (frame_tbl[i]) exp_q.push_back(frame_tbl[i]);
        hs_cyc_q.delete();
        en_snap = en_cnt0;
        d_snap  = done_cnt0;
        @(posedge clk); #1;
        start0 = 1'b1;
        c0 = cyc;
        pix0.pix_ready = (mode == 2) ? 1'b0 : ((mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1);
        @(posedge clk); #1;
        start0 = 1'b0;
        chk("busy_after_start", int'(busy0), 1);
        n = 0;
        while (done_cnt0 == d_snap && n < 400) begin
            if (mode == 1) begin
                pix0.pix_ready = 1'($urandom_range(0, 1));
            end else if (mode == 2) begin
                if (cyc == c0 + 21) begin
                    chk("stall_reads", en_cnt0 - en_snap, 2);
                    chk("stall_valid", int'(pix0.pix_valid), 1);
                    chk("stall_pix", int'(pix0.pix_out), 0);
                end
                pix0.pix_ready = (cyc >= c0 + 21);
            end
            @(posedge clk); #1;
            n++;
        end
        chk("frame_done_seen", int'(n < 400), 1);
        chk("busy_after_done", int'(busy0), 0);
        chk("sb_drained", exp_q.size(), 0);
        chk("frame_reads", en_cnt0 - en_snap, NPIX);
        if (mode == 0) begin
            chk("hs_count", hs_cyc_q.size(), NPIX);
            if (hs_cyc_q.size() == NPIX) begin
                for (int i = 0; i < NPIX; i++) chk("hs_cycle", hs_cyc_q[i] - c0, 3 + i);
            end
            chk("done_cycle", last_done0 - c0, 3 + NPIX - 1);
        end
    endtask

    int case_tbl [3];

    initial begin
        int c0, n, en_snap, d_snap;

        frame_tbl[0]  = '{pix: 8'd0,  mk: 4'b1100};
        frame_tbl[1]  = '{pix: 8'd1,  mk: 4'b0000};
        frame_tbl[2]  = '{pix: 8'd2,  mk: 4'b0000};
        frame_tbl[3]  = '{pix: 8'd3,  mk: 4'b0010};
        frame_tbl[4]  = '{pix: 8'd4,  mk: 4'b0100};
        frame_tbl[5]  = '{pix: 8'd5,  mk: 4'b0000};
        frame_tbl[6]  = '{pix: 8'd6,  mk: 4'b0000};
        frame_tbl[7]  = '{pix: 8'd7,  mk: 4'b0010};
        frame_tbl[8]  = '{pix: 8'd8,  mk: 4'b0100};
        frame_tbl[9]  = '{pix: 8'd9,  mk: 4'b0000};
        frame_tbl[10] = '{pix: 8'd10, mk: 4'b0000};
        frame_tbl[11] = '{pix: 8'd11, mk: 4'b0011};
        case_tbl = '{0, 1, 2};

        rst = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        pix0.pix_ready = 1'b0;
        pix1.pix_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy0), 0);
        chk("rst_done", int'(done0), 0);
        chk("rst_mem_en", int'(en0), 0);
        chk("rst_mem_addr", int'(addr0), 0);
        chk("rst_valid", int'(pix0.pix_valid), 0);
        chk("rst_pix", int'(pix0.pix_out), 0);
        chk("rst_marks", int'({pix0.sof, pix0.sol, pix0.eol, pix0.eof}), 0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 3; k++) run_frame(case_tbl[k]);

        // blanking between lines
        @(posedge clk); #1;
        start1 = 1'b1;
        c0 = cyc;
        @(posedge clk); #1;
        start1 = 1'b0;
        n = 0;
        while (done_cnt1 == 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("hb_done_seen", int'(n < 200), 1);
        chk("hb_issue_count", iss_cyc1.size(), NPIX);
        chk("hb_out_count", hs1_cyc.size(), NPIX);
        if (iss_cyc1.size() == NPIX && hs1_cyc.size() == NPIX) begin
            for (int a = 0; a < NPIX; a++) begin
                chk("hb_issue_addr", iss_addr1[a], a);
                chk("hb_issue_cycle", iss_cyc1[a] - c0, 1 + a + 2 * (a / W));
                chk("hb_out_cycle", hs1_cyc[a] - c0, 3 + a + 2 * (a / W));
                chk("hb_out_pix", hs1_pix[a], a);
            end
        end

        // reset in the middle of the frame
        foreach (frame_tbl[i]) exp_q.push_back(frame_tbl[i]);
        @(posedge clk); #1;
        start0 = 1'b1;
        pix0.pix_ready = 1'b1;
        c0 = cyc;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        chk("mid_rst_pre_valid", int'(pix0.pix_valid), 1);
        chk("mid_rst_pre_pix", int'(pix0.pix_out), 5);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_busy", int'(busy0), 0);
        chk("mid_rst_done", int'(done0), 0);
        chk("mid_rst_mem_en", int'(en0), 0);
        chk("mid_rst_addr", int'(addr0), 0);
        chk("mid_rst_valid", int'(pix0.pix_valid), 0);
        chk("mid_rst_pix", int'(pix0.pix_out), 0);
        chk("mid_rst_marks", int'({pix0.sof, pix0.sol, pix0.eol, pix0.eof}), 0);
        rst = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("no_stale_valid", int'(pix0.pix_valid), 0);
        end
        run_frame(0);

        // start pulses while busy and on the done cycle are ignored
        foreach (frame_tbl[i]) exp_q.push_back(frame_tbl[i]);
        en_snap = en_cnt0;
        d_snap  = done_cnt0;
        @(posedge clk); #1;
        start0 = 1'b1;
        pix0.pix_ready = 1'b1;
        c0 = cyc;
        for (int t = 1; t <= 24; t++) begin
            @(posedge clk); #1;
            start0 = (t == 9 || t == 14);
        end
        start0 = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("dup_start_done_count", done_cnt0 - d_snap, 1);
        chk("dup_start_reads", en_cnt0 - en_snap, NPIX);
        chk("dup_start_sb_drained", exp_q.size(), 0);
        chk("dup_start_done_cycle", last_done0 - c0, 14);
        chk("dup_start_busy", int'(busy0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/frame_streamer.md
Name: frame_streamer

Overview:
- Raster pixel transmitter: reads one frame from a synchronous frame RAM and emits it as a pixel stream.
- Uses a valid/ready handshake plus line/frame markers.
- Sits upstream of line_buff and the edge-detection window logic, which consume the stream row by row.
- Handles 1-cycle RAM read latency and downstream backpressure without losing or duplicating pixels.

Parameters:
- BITSIZE, 8, pixel width in bits
- WIDTH, 480, pixels per line (must be at least 2)
- HEIGHT, 272, lines per frame (must be at least 1)
- ADDR_W, 17, frame RAM address width (must satisfy 2^ADDR_W >= WIDTH*HEIGHT)
- HBLANK, 0, idle fetch cycles inserted between lines (0 = back-to-back)

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous reset, active-low
- start  in  1  begin frame; honoured only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse on the handshake of the last pixel
- mem_en  out  1  RAM read enable
- mem_addr  out  ADDR_W  RAM read address, row-major (row*WIDTH+col)
- mem_rdata  in  BITSIZE  RAM data, valid exactly 1 cycle after mem_en
- pix_out  out  BITSIZE  pixel data
- pix_valid  out  1  pix_out and markers valid
- pix_ready  in  1  downstream accepts when high with pix_valid
- sof  out  1  with pixel (0,0)
- sol  out  1  with col 0 of each row
- eol  out  1  with col WIDTH-1 of each row
- eof  out  1  with pixel (WIDTH-1,HEIGHT-1)

Behaviour:
- Reset (rst=0 at posedge):
  - FSM goes to IDLE; fetch col/row/address counters and the HBLANK counter clear to 0.
  - Outstanding-read flag clears; the output FIFO empties.
  - All outputs are 0, including mem_addr and pix_out.
  - A RAM response already in flight is discarded, because the outstanding flag is clear.
- FSM states IDLE, FETCH, HBLANK, DRAIN.
  - IDLE: start=1 -> FETCH; busy=1 from the next cycle.
  - FETCH:
    - issues one read per cycle while credit allows; the address counter increments, with no multiplier.
    - After issuing col WIDTH-1: if it was the last row -> DRAIN; else if HBLANK>0 -> HBLANK; else stay in FETCH at col 0 of the next row.
  - HBLANK: count HBLANK cycles with mem_en=0, then -> FETCH. Output keeps draining.
  - DRAIN: no issues. When the eof pixel handshakes: done=1 that cycle, then -> IDLE, and busy=0 the following cycle.
- Credit rule: issue iff in FETCH and (fifo_count + outstanding - pop) < 2, where pop = pix_valid & pix_ready.
- FIFO capture:
  - The 2-entry FIFO captures mem_rdata together with the sof/sol/eol/eof flags, one cycle after mem_en.
  - The flags are computed from the fetch col/row and pipelined with the read.
- Output: pix_valid = FIFO not empty; pix_out and all markers come from the FIFO head.
  - While pix_valid=1 and pix_ready=0, pix_out and the markers hold stable.
- Latency: start high in cycle 0 -> mem_en in cycle 1 -> pix_valid in cycle 3.
- Throughput: with pix_ready held high and HBLANK=0, exactly 1 pixel/clk until eof.
- Simultaneous push and pop with a full FIFO: legal. The count is unchanged and order is preserved.
- start while busy: ignored and not queued. start on the done cycle is also ignored.
- WIDTH*HEIGHT pixels per frame exactly: each address is read once, in increasing order, with no gaps other than HBLANK.
- With HEIGHT=1, sof and sol both coincide on pixel 0, and eol and eof both coincide on the last pixel.

Decomposition:
- Shared package (edge_pkg): BITSIZE, default image WIDTH/HEIGHT, and the derived ADDR_W calculation shared with line_buff and the window/Sobel blocks.
- One natural sub-module, stream_skid2: a 2-entry FIFO with parameterised data width.
  - Carries BITSIZE+4 bits (pixel plus markers).
  - Exposes count, push, and pop.
  - Reused later by the Sobel output stage.

Test Plan:
- WIDTH=4, HEIGHT=3, HBLANK=0, RAM[a]=a, pix_ready=1:
  - pix_out 0..11 on consecutive cycles, first valid 3 cycles after start.
  - sof on 0; sol on 0,4,8; eol on 3,7,11; eof on 11.
  - done one cycle with pixel 11; busy low the next cycle.
- Same config, pix_ready randomly low ~50%:
  - the accepted sequence is exactly 0..11 with correct markers;
  - pix_out stays stable whenever pix_valid=1 and pix_ready=0.
- pix_ready=0 for 20 cycles after start: at most 2 reads are issued and pix_out holds 0. On release, 0..11 stream with no loss or duplication.
- HBLANK=2, pix_ready=1: mem_en is low for exactly 2 cycles after addresses 3 and 7. The output shows matching 2-cycle pix_valid gaps.
- rst=0 asserted during pixel 5:
  - next cycle all outputs are 0 and the FSM is in IDLE;
  - a new start restarts from address 0 with sof set, with no stale pixel.
- start pulsed again at pixel 6 while busy: ignored. Exactly 12 pixels and one done pulse result.
